// File: rtl/coord_pkg.sv
// Shared grid-coordinate constants for the input-processing unit and the processor grid path.
package coord_pkg;

    localparam int unsigned COORD_W    = 4;
    localparam int unsigned GRID_CELLS = 9;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic logic coord_legal(input logic [31:0] coord, input int unsigned cells);
        return coord < cells;
    endfunction

endpackage

// File: rtl/coord_fifo_ram.sv
// Coordinate storage: DEPTH x COORD_W register array, synchronous write, asynchronous read.
module coord_fifo_ram #(
    parameter int unsigned COORD_W = coord_pkg::COORD_W,
    parameter int unsigned DEPTH   = coord_pkg::FIFO_DEPTH,
    parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  logic [COORD_W-1:0] wdata,
    input  logic [PTR_W-1:0]   raddr,
    output logic [COORD_W-1:0] rdata
);

    logic [COORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/coord_int_fifo.sv
// Coordinate FIFO between the input-processing unit and the processor, raising ipu_int while non-empty.
// Optional range check on pushed coordinates enabled by defining COORD_RANGE_CHECK_EN.
module coord_int_fifo #(
    parameter int unsigned COORD_W    = coord_pkg::COORD_W,
    parameter int unsigned DEPTH      = coord_pkg::FIFO_DEPTH,
    parameter int unsigned GRID_CELLS = coord_pkg::GRID_CELLS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [COORD_W-1:0]       coord_in,
    input  logic                     int_ack,
    input  logic                     ovf_clr,
    output logic [COORD_W-1:0]       coord_out,
    output logic                     ipu_int,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     bad_coord
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               coord_ok, push_req, push, pop, full_w, empty_w;
    logic [COORD_W-1:0] rd_data;
    coord_pkg::fifo_op_e op;

`ifdef COORD_RANGE_CHECK_EN
    logic bad_q, bad_d;
    assign coord_ok  = coord_pkg::coord_legal(32'(coord_in), GRID_CELLS);
    assign bad_coord = bad_q;
`else
    assign coord_ok  = 1'b1;
    assign bad_coord = 1'b0;
`endif

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign push_req = write_en & coord_ok;
    assign pop      = int_ack & ~empty_w;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push     = push_req & (~full_w | pop);
    assign op       = coord_pkg::fifo_op_e'({push, pop});

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (op)
            coord_pkg::OP_PUSH: begin
                tail_d  = tail_q + PTR_W'(1);
                count_d = count_q + CNT_W'(1);
            end
            coord_pkg::OP_POP: begin
                head_d  = head_q + PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
            coord_pkg::OP_BOTH: begin
                head_d = head_q + PTR_W'(1);
                tail_d = tail_q + PTR_W'(1);
            end
            default: ;
        endcase
    end

    // Setting events take priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_clr ? 1'b0 : ovf_q;
        if (push_req & full_w & ~pop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef COORD_RANGE_CHECK_EN
    always_comb begin
        bad_d = ovf_clr ? 1'b0 : bad_q;
        if (write_en & ~coord_ok) begin
            bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    coord_fifo_ram #(
        .COORD_W (COORD_W),
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (tail_q),
        .wdata (coord_in),
        .raddr (head_q),
        .rdata (rd_data)
    );

    assign coord_out = empty_w ? '0 : rd_data;
    assign ipu_int   = ~empty_w;
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_coord_int_fifo.sv
// Directed self-checking bench for coord_int_fifo (default parameters); honours COORD_RANGE_CHECK_EN.
module tb_coord_int_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_en = 1'b0;
    logic [3:0] coord_in = '0;
    logic       int_ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] coord_out;
    logic       ipu_int;
    logic [2:0] count;
    logic       full, empty, overflow, bad_coord;

    int n_checks = 0;
    int n_fail   = 0;

    coord_int_fifo #(
        .COORD_W    (4),
        .DEPTH      (4),
        .GRID_CELLS (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .coord_in  (coord_in),
        .int_ack   (int_ack),
        .ovf_clr   (ovf_clr),
        .coord_out (coord_out),
        .ipu_int   (ipu_int),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .bad_coord (bad_coord)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=no finish required=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic we, input logic [3:0] d, input logic ack, input logic clr);
        write_en = we;
        coord_in = d;
        int_ack  = ack;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        int_ack  = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_int"}, 32'(ipu_int), 32'd0);
        chk({tag, "_cout"}, 32'(coord_out), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_bad"}, 32'(bad_coord), 32'd0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Single push / ack
        step(1'b1, 4'd5, 1'b0, 1'b0);
        chk("push5_int", 32'(ipu_int), 32'd1);
        chk("push5_cout", 32'(coord_out), 32'd5);
        chk("push5_count", 32'(count), 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("ack_int", 32'(ipu_int), 32'd0);
        chk("ack_empty", 32'(empty), 32'd1);
        chk("ack_cout", 32'(coord_out), 32'd0);

        // Ack while empty is ignored
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("ack_empty_count", 32'(count), 32'd0);

        // Fill, overflow, drain in order
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", 32'(coord_out), 32'd1);
        chk("pop_1", 32'(coord_out), 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("pop_2", 32'(coord_out), 32'd2);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("pop_3", 32'(coord_out), 32'd3);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("pop_4", 32'(coord_out), 32'd4);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Push+pop at full, pointer wrap, set-wins-over-clear
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b1, 4'd8, 1'b1, 1'b0);
        chk("both_full_count", 32'(count), 32'd4);
        chk("both_full_ovf", 32'(overflow), 32'd1);
        chk("wrap_2", 32'(coord_out), 32'd2);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("wrap_3", 32'(coord_out), 32'd3);
        chk("clr_ovf2", 32'(overflow), 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("wrap_4", 32'(coord_out), 32'd4);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("wrap_8", 32'(coord_out), 32'd8);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("wrap_empty", 32'(count), 32'd0);

        // Push and pop at empty
        step(1'b1, 4'd6, 1'b1, 1'b0);
        chk("both_empty_count", 32'(count), 32'd1);
        chk("both_empty_cout", 32'(coord_out), 32'd6);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("both_empty_drain", 32'(count), 32'd0);

        // Out-of-range coordinate
        step(1'b1, 4'd9, 1'b0, 1'b0);
`ifdef COORD_RANGE_CHECK_EN
        chk("range_bad", 32'(bad_coord), 32'd1);
        chk("range_count", 32'(count), 32'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("range_clr", 32'(bad_coord), 32'd0);
`else
        chk("range_count", 32'(count), 32'd1);
        chk("range_cout", 32'(coord_out), 32'd9);
        chk("range_bad", 32'(bad_coord), 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("range_drain", 32'(count), 32'd0);
`endif

        // Asynchronous reset mid-cycle with count=3
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd4);
        chk("pre_rst_ovf", 32'(overflow), 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("pre_rst_count3", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        write_en = 1'b1;
        coord_in = 4'd3;
        int_ack  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_push_ignored", 32'(count), 32'd0);
        write_en = 1'b0;
        int_ack  = 1'b0;
        rst = 1'b0;
        step(1'b1, 4'd4, 1'b0, 1'b0);
        chk("resume_count", 32'(count), 32'd1);
        chk("resume_cout", 32'(coord_out), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
